// File: rtl/axi_pkg.sv
// Shared AXI slave definitions: FSM state encoding and response codes.
// Used by axi_mem_slave (build option: AXI_MEM_SLAVE_ADDR_CHECK_EN).
package axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_DATA = 2'd1,
      ST_WR_RESP = 2'd2,
      ST_RD_DATA = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI-style burst bus bundle between a master and axi_mem_slave.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

interface axi_mem_slave_if #(
   parameter int ADDR_W = `AXI_ADDR_WIDTH,
   parameter int DATA_W = `AXI_DATA_WIDTH,
   parameter int ID_W   = `AXI_ID_WIDTH
);
   logic                aw_valid;
   logic                aw_ready;
   logic [ADDR_W-1:0]   aw_addr;
   logic [ID_W-1:0]     aw_id;
   logic [7:0]          aw_len;

   logic                w_valid;
   logic                w_ready;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                w_last;

   logic                b_valid;
   logic                b_ready;
   logic [1:0]          b_resp;
   logic [ID_W-1:0]     b_id;

   logic                ar_valid;
   logic                ar_ready;
   logic [ADDR_W-1:0]   ar_addr;
   logic [ID_W-1:0]     ar_id;
   logic [7:0]          ar_len;

   logic                r_valid;
   logic                r_ready;
   logic [DATA_W-1:0]   r_data;
   logic [1:0]          r_resp;
   logic                r_last;
   logic [ID_W-1:0]     r_id;

   modport slave (
      input  aw_valid, aw_addr, aw_id, aw_len,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_resp, b_id,
      input  b_ready,
      input  ar_valid, ar_addr, ar_id, ar_len,
      output ar_ready,
      output r_valid, r_data, r_resp, r_last, r_id,
      input  r_ready
   );

   modport master (
      output aw_valid, aw_addr, aw_id, aw_len,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_resp, b_id,
      output b_ready,
      output ar_valid, ar_addr, ar_id, ar_len,
      input  ar_ready,
      input  r_valid, r_data, r_resp, r_last, r_id,
      output r_ready
   );

endinterface

// File: rtl/axi_mem_array.sv
// Word-addressed storage with per-byte write enables and a registered read port.
module axi_mem_array #(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = 4096,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int NB     = DATA_W / 8
) (
   input  logic              clock,
   input  logic              we,
   input  logic [IDX_W-1:0]  w_idx,
   input  logic [DATA_W-1:0] w_data,
   input  logic [NB-1:0]     w_strb,
   input  logic [IDX_W-1:0]  r_idx,
   output logic [DATA_W-1:0] r_data
);

   // One narrow array per byte lane keeps each lane a plain single-port-write RAM.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] rd_byte_reg;

         always_ff @(posedge clock) begin
            if (we && w_strb[gi]) begin
               lane_mem[w_idx] <= w_data[gi*8 +: 8];
            end
            rd_byte_reg <= lane_mem[r_idx];
         end

         assign r_data[gi*8 +: 8] = rd_byte_reg;
      end
   endgenerate

endmodule

// File: rtl/axi_mem_slave.sv
// Single-transaction AXI burst memory slave with round-robin AW/AR arbitration.
// Build option AXI_MEM_SLAVE_ADDR_CHECK_EN: out-of-range beats return SLVERR instead of wrapping.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_mem_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W    = `AXI_ADDR_WIDTH,
   parameter int DATA_W    = `AXI_DATA_WIDTH,
   parameter int ID_W      = `AXI_ID_WIDTH,
   parameter int MEM_DEPTH = 4096
) (
   input  logic            clock,
   input  logic            reset,
   axi_mem_slave_if.slave  bus
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int WA_W  = ADDR_W - OFF_W;

   state_t            state_reg, state_next;
   logic              prefer_rd_reg;
   logic [ID_W-1:0]   id_reg;
   logic [7:0]        len_reg;
   logic [7:0]        beat_reg;
   logic [WA_W-1:0]   word_reg;
   logic              wr_err_reg;
   logic              r_valid_reg;
   logic              r_last_reg;
   logic              r_err_reg;

   logic              aw_ready_c, ar_ready_c, w_ready_c, b_valid_c;
   logic              grant_rd, grant_wr;
   logic              w_hs, r_hs, last_beat;
   logic [WA_W-1:0]   aw_word, ar_word, word_next;
   logic              cur_err, nxt_err, ar_err;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_r_idx;
   logic [DATA_W-1:0] mem_r_data;
   logic              unused_addr;

   assign aw_word   = bus.aw_addr[ADDR_W-1:OFF_W];
   assign ar_word   = bus.ar_addr[ADDR_W-1:OFF_W];
   assign word_next = word_reg + WA_W'(1);
   assign last_beat = (beat_reg == len_reg);

   // On a tie, serve the direction that did not win last time.
   assign grant_rd = bus.ar_valid && (!bus.aw_valid || prefer_rd_reg);
   assign grant_wr = bus.aw_valid && !grant_rd;

   assign w_hs = (state_reg == ST_WR_DATA) && bus.w_valid;
   assign r_hs = (state_reg == ST_RD_DATA) && r_valid_reg && bus.r_ready;

`ifdef AXI_MEM_SLAVE_ADDR_CHECK_EN
   assign cur_err     = |word_reg[WA_W-1:IDX_W];
   assign nxt_err     = |word_next[WA_W-1:IDX_W];
   assign ar_err      = |ar_word[WA_W-1:IDX_W];
   assign unused_addr = ^{bus.aw_addr[OFF_W-1:0], bus.ar_addr[OFF_W-1:0]};
`else
   assign cur_err     = 1'b0;
   assign nxt_err     = 1'b0;
   assign ar_err      = 1'b0;
   assign unused_addr = ^{bus.aw_addr[OFF_W-1:0], bus.ar_addr[OFF_W-1:0],
                          word_next[WA_W-1:IDX_W], ar_word[WA_W-1:IDX_W]};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      aw_ready_c = 1'b0;
      ar_ready_c = 1'b0;
      w_ready_c  = 1'b0;
      b_valid_c  = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (!reset) begin
               if (grant_wr) begin
                  aw_ready_c = 1'b1;
                  state_next = ST_WR_DATA;
               end else if (grant_rd) begin
                  ar_ready_c = 1'b1;
                  state_next = ST_RD_DATA;
               end
            end
         end
         ST_WR_DATA: begin
            w_ready_c = 1'b1;
            if (bus.w_valid && last_beat) begin
               state_next = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            b_valid_c = 1'b1;
            if (bus.b_ready) begin
               state_next = ST_IDLE;
            end
         end
         ST_RD_DATA: begin
            if (r_hs && r_last_reg) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prefer_rd_reg <= 1'b0;
         id_reg        <= '0;
         len_reg       <= '0;
         beat_reg      <= '0;
         word_reg      <= '0;
         wr_err_reg    <= 1'b0;
         r_valid_reg   <= 1'b0;
         r_last_reg    <= 1'b0;
         r_err_reg     <= 1'b0;
      end else begin
         if (aw_ready_c) begin
            prefer_rd_reg <= 1'b1;
            id_reg        <= bus.aw_id;
            len_reg       <= bus.aw_len;
            beat_reg      <= '0;
            word_reg      <= aw_word;
            wr_err_reg    <= 1'b0;
         end
         if (ar_ready_c) begin
            prefer_rd_reg <= 1'b0;
            id_reg        <= bus.ar_id;
            len_reg       <= bus.ar_len;
            beat_reg      <= '0;
            word_reg      <= ar_word;
            r_valid_reg   <= 1'b1;
            r_last_reg    <= (bus.ar_len == 8'd0);
            r_err_reg     <= ar_err;
         end
         if (w_hs) begin
            beat_reg <= beat_reg + 8'd1;
            word_reg <= word_next;
            // Misplaced or missing w_last only flags the response; aw_len still sets the length.
            if ((bus.w_last != last_beat) || cur_err) begin
               wr_err_reg <= 1'b1;
            end
         end
         if (r_hs) begin
            if (r_last_reg) begin
               r_valid_reg <= 1'b0;
               r_last_reg  <= 1'b0;
               r_err_reg   <= 1'b0;
            end else begin
               beat_reg   <= beat_reg + 8'd1;
               word_reg   <= word_next;
               r_last_reg <= (beat_reg + 8'd1 == len_reg);
               r_err_reg  <= nxt_err;
            end
         end
      end
   end

   // Re-reading the current word while stalled keeps r_data stable without a skid buffer.
   always_comb begin
      mem_r_idx = word_reg[IDX_W-1:0];
      if (ar_ready_c) begin
         mem_r_idx = ar_word[IDX_W-1:0];
      end else if (r_hs) begin
         mem_r_idx = word_next[IDX_W-1:0];
      end
   end

   assign mem_we = w_hs && !cur_err;

   axi_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clock  (clock),
      .we     (mem_we),
      .w_idx  (word_reg[IDX_W-1:0]),
      .w_data (bus.w_data),
      .w_strb (bus.w_strb),
      .r_idx  (mem_r_idx),
      .r_data (mem_r_data)
   );

   assign bus.aw_ready = aw_ready_c;
   assign bus.ar_ready = ar_ready_c;
   assign bus.w_ready  = w_ready_c;
   assign bus.b_valid  = b_valid_c;
   assign bus.b_resp   = resp_of(wr_err_reg);
   assign bus.b_id     = id_reg;
   assign bus.r_valid  = r_valid_reg;
   assign bus.r_data   = r_err_reg ? '0 : mem_r_data;
   assign bus.r_resp   = resp_of(r_err_reg);
   assign bus.r_last   = r_last_reg;
   assign bus.r_id     = id_reg;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (optionally with AXI_MEM_SLAVE_ADDR_CHECK_EN).
module tb_axi_mem_slave;
   import axi_pkg::*;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int ID_W      = 4;
   localparam int MEM_DEPTH = 4096;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   axi_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

   axi_mem_slave #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .ID_W      (ID_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [63:0] wd [256];
   logic [7:0]  ws [256];
   logic [63:0] ed [256];
   logic [1:0]  er [256];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic aw_hs(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
      bit ok;
      ok = 1'b0;
      bus.aw_valid = 1'b1;
      bus.aw_addr  = addr;
      bus.aw_id    = id;
      bus.aw_len   = len;
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         if (bus.aw_ready) ok = 1'b1;
         tick();
      end
      bus.aw_valid = 1'b0;
      check("aw_handshake", 64'(ok), 64'd1);
   endtask

   task automatic ar_hs(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
      bit ok;
      ok = 1'b0;
      bus.ar_valid = 1'b1;
      bus.ar_addr  = addr;
      bus.ar_id    = id;
      bus.ar_len   = len;
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         if (bus.ar_ready) ok = 1'b1;
         tick();
      end
      bus.ar_valid = 1'b0;
      check("ar_handshake", 64'(ok), 64'd1);
   endtask

   task automatic w_beats(input int len, input int last_at);
      for (int i = 0; i <= len; i++) begin
         bit ok;
         ok = 1'b0;
         bus.w_valid = 1'b1;
         bus.w_data  = wd[i];
         bus.w_strb  = ws[i];
         bus.w_last  = (i == last_at);
         for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            if (bus.w_ready) ok = 1'b1;
            tick();
         end
         check("w_handshake", 64'(ok), 64'd1);
      end
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
   endtask

   task automatic b_wait(input logic [3:0] id, input logic [1:0] resp);
      bit ok;
      ok = 1'b0;
      bus.b_ready = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         if (bus.b_valid) begin
            ok = 1'b1;
            check("b_resp", 64'(bus.b_resp), 64'(resp));
            check("b_id", 64'(bus.b_id), 64'(id));
         end
         tick();
      end
      bus.b_ready = 1'b0;
      check("b_handshake", 64'(ok), 64'd1);
   endtask

   task automatic wr_burst(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input int last_at, input logic [1:0] resp);
      aw_hs(addr, id, 8'(len));
      w_beats(len, last_at);
      b_wait(id, resp);
   endtask

   task automatic rd_burst(input logic [31:0] addr, input logic [3:0] id, input int len);
      ar_hs(addr, id, 8'(len));
      bus.r_ready = 1'b1;
      for (int i = 0; i <= len; i++) begin
         bit ok;
         ok = 1'b0;
         for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            if (i == 0 && n == 0) check("r_valid_latency", 64'(bus.r_valid), 64'd1);
            if (bus.r_valid) begin
               ok = 1'b1;
               check("r_data", bus.r_data, ed[i]);
               check("r_resp", 64'(bus.r_resp), 64'(er[i]));
               check("r_last", 64'(bus.r_last), 64'(i == len));
               check("r_id", 64'(bus.r_id), 64'(id));
            end
            tick();
         end
         check("r_handshake", 64'(ok), 64'd1);
      end
      bus.r_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int beat;
      bus.aw_valid = 1'b1; bus.aw_addr = '0; bus.aw_id = '0; bus.aw_len = '0;
      bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0; bus.w_last = 1'b0;
      bus.b_ready  = 1'b0;
      bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_id = '0; bus.ar_len = '0;
      bus.r_ready  = 1'b0;
      for (int i = 0; i < 256; i++) begin
         ws[i] = 8'hFF;
         er[i] = RESP_OKAY;
      end

      // Reset state, including ready held low despite a pending request.
      repeat (3) tick();
      #1;
      check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
      check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
      check("rst_w_ready", 64'(bus.w_ready), 64'd0);
      check("rst_b_valid", 64'(bus.b_valid), 64'd0);
      check("rst_r_valid", 64'(bus.r_valid), 64'd0);
      check("rst_r_last", 64'(bus.r_last), 64'd0);
      check("rst_b_resp", 64'(bus.b_resp), 64'd0);
      check("rst_r_resp", 64'(bus.r_resp), 64'd0);
      bus.aw_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      // Basic 4-beat write then read.
      for (int i = 0; i < 4; i++) begin
         wd[i] = {32'hCAFE0000 + 32'(i), 32'h12340000 + 32'(i)};
         ed[i] = wd[i];
      end
      wr_burst(32'h100, 4'h6, 3, 3, RESP_OKAY);
      rd_burst(32'h100, 4'h9, 3);

      // Partial byte-enable merge.
      wd[0] = 64'h11111111_22222222;
      wr_burst(32'h180, 4'h1, 0, 0, RESP_OKAY);
      wd[0] = 64'hAAAAAAAA_BBBBBBBB; ws[0] = 8'h0F;
      wr_burst(32'h180, 4'h2, 0, 0, RESP_OKAY);
      ws[0] = 8'hFF;
      ed[0] = 64'h11111111_BBBBBBBB;
      rd_burst(32'h180, 4'h3, 0);

      // Tie 1: write wins, pending read served afterwards.
      bus.aw_valid = 1'b1; bus.aw_addr = 32'h200; bus.aw_id = 4'hA; bus.aw_len = 8'd0;
      bus.ar_valid = 1'b1; bus.ar_addr = 32'h200; bus.ar_id = 4'hB; bus.ar_len = 8'd0;
      #1;
      check("tie1_aw_ready", 64'(bus.aw_ready), 64'd1);
      check("tie1_ar_ready", 64'(bus.ar_ready), 64'd0);
      tick();
      bus.aw_valid = 1'b0;
      #1;
      check("ar_blocked_in_write", 64'(bus.ar_ready), 64'd0);
      wd[0] = 64'h01234567_89ABCDEF;
      w_beats(0, 0);
      b_wait(4'hA, RESP_OKAY);
      #1;
      check("pending_read_granted", 64'(bus.ar_ready), 64'd1);
      ed[0] = 64'h01234567_89ABCDEF;
      rd_burst(32'h200, 4'hB, 0);

      // Tie 2: last grant was a read, so write wins again.
      bus.aw_valid = 1'b1; bus.aw_addr = 32'h208; bus.aw_id = 4'h1; bus.aw_len = 8'd0;
      bus.ar_valid = 1'b1; bus.ar_addr = 32'h200; bus.ar_id = 4'h2; bus.ar_len = 8'd0;
      #1;
      check("tie2_aw_ready", 64'(bus.aw_ready), 64'd1);
      check("tie2_ar_ready", 64'(bus.ar_ready), 64'd0);
      tick();
      bus.aw_valid = 1'b0;
      wd[0] = 64'h0BADF00D_00000208;
      w_beats(0, 0);
      b_wait(4'h1, RESP_OKAY);
      rd_burst(32'h200, 4'h2, 0);

      // Read with r_ready toggling every cycle.
      for (int i = 0; i < 8; i++) begin
         wd[i] = {32'h30000000 + 32'(i * 17), 32'hF0F00000 + 32'(i)};
         ed[i] = wd[i];
      end
      wr_burst(32'h300, 4'h5, 7, 7, RESP_OKAY);
      ar_hs(32'h300, 4'h7, 8'd7);
      beat = 0;
      for (int c = 0; c < 40 && beat < 8; c++) begin
         bus.r_ready = ((c % 2) == 0);
         #1;
         if (bus.r_valid) begin
            check("toggle_data", bus.r_data, ed[beat]);
            check("toggle_last", 64'(bus.r_last), 64'(beat == 7));
            if (bus.r_ready) beat++;
         end
         tick();
      end
      bus.r_ready = 1'b0;
      check("toggle_beats", 64'(beat), 64'd8);
      #1;
      check("toggle_done_r_valid", 64'(bus.r_valid), 64'd0);
      tick();

      // Early w_last: all four beats still written, SLVERR response.
      for (int i = 0; i < 4; i++) begin
         wd[i] = {32'h40400000, 32'(i) + 32'h55};
         ed[i] = wd[i];
      end
      wr_burst(32'h400, 4'h3, 3, 1, RESP_SLVERR);
      rd_burst(32'h400, 4'h4, 3);

      // Reset in the middle of a read burst.
      ar_hs(32'h300, 4'h4, 8'd7);
      bus.r_ready = 1'b1;
      tick();
      tick();
      bus.r_ready = 1'b0;
      reset = 1'b1;
      tick();
      #1;
      check("midrst_r_valid", 64'(bus.r_valid), 64'd0);
      check("midrst_r_last", 64'(bus.r_last), 64'd0);
      check("midrst_b_resp", 64'(bus.b_resp), 64'd0);
      check("midrst_b_valid", 64'(bus.b_valid), 64'd0);
      reset = 1'b0;
      tick();
      bus.aw_valid = 1'b1; bus.aw_addr = 32'h500; bus.aw_id = 4'hC; bus.aw_len = 8'd0;
      bus.ar_valid = 1'b1; bus.ar_addr = 32'h300; bus.ar_id = 4'hD; bus.ar_len = 8'd0;
      #1;
      check("postrst_tie_aw", 64'(bus.aw_ready), 64'd1);
      check("postrst_tie_ar", 64'(bus.ar_ready), 64'd0);
      tick();
      bus.aw_valid = 1'b0;
      wd[0] = 64'h50050050_05005005;
      w_beats(0, 0);
      b_wait(4'hC, RESP_OKAY);
      ed[0] = {32'h30000000, 32'hF0F00000};
      rd_burst(32'h300, 4'hD, 0);

      // 256-beat burst.
      for (int i = 0; i < 256; i++) begin
         wd[i] = {32'hA5A50000 + 32'(i), ~(32'h0 + 32'(i))};
         ed[i] = wd[i];
      end
      wr_burst(32'h4000, 4'hF, 255, 255, RESP_OKAY);
      rd_burst(32'h4000, 4'hE, 255);

      // Top-of-memory boundary: wrap by default, SLVERR with the address check.
      wd[0] = 64'hFEED0000_00000001;
      wd[1] = 64'hFEED0000_00000002;
`ifdef AXI_MEM_SLAVE_ADDR_CHECK_EN
      wr_burst(32'h7FF8, 4'h6, 1, 1, RESP_SLVERR);
      ed[0] = wd[0];        er[0] = RESP_OKAY;
      ed[1] = 64'h0;        er[1] = RESP_SLVERR;
      rd_burst(32'h7FF8, 4'h8, 1);
      ed[0] = 64'h0;        er[0] = RESP_SLVERR;
      rd_burst(32'h8000, 4'h9, 0);
`else
      wr_burst(32'h7FF8, 4'h6, 1, 1, RESP_OKAY);
      ed[0] = wd[0];        er[0] = RESP_OKAY;
      ed[1] = wd[1];        er[1] = RESP_OKAY;
      rd_burst(32'h7FF8, 4'h8, 1);
      ed[0] = wd[1];        er[0] = RESP_OKAY;
      rd_burst(32'h8000, 4'h9, 0);
`endif
      er[0] = RESP_OKAY;
      er[1] = RESP_OKAY;

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width (= `AXI_ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_W, default 64, data width (= `AXI_DATA_WIDTH).
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width (= `AXI_ID_WIDTH).
REQ-004 SHALL have parameter MEM_DEPTH, default 4096, number of DATA_W words, power of two.
REQ-005 SHALL have port clock, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port aw_valid, input, 1, write address valid.
REQ-008 SHALL have port aw_ready, output, 1, write address accepted.
REQ-009 SHALL have port aw_addr, input, ADDR_W, burst start byte address.
REQ-010 SHALL have port aw_id, input, ID_W, write ID.
REQ-011 SHALL have port aw_len, input, 8, beats minus one.
REQ-012 SHALL have port w_valid, input, 1, write data valid.
REQ-013 SHALL have port w_ready, output, 1, write data accepted.
REQ-014 SHALL have port w_data, input, DATA_W, write beat.
REQ-015 SHALL have port w_strb, input, DATA_W/8, byte enables.
REQ-016 SHALL have port w_last, input, 1, final write beat marker.
REQ-017 SHALL have port b_valid, output, 1, write response valid.
REQ-018 SHALL have port b_ready, input, 1, write response accepted.
REQ-019 SHALL have port b_resp, output, 2, 00 OKAY / 10 SLVERR.
REQ-020 SHALL have port b_id, output, ID_W, echo of aw_id.
REQ-021 SHALL have ports ar_valid/ar_ready/ar_addr/ar_id/ar_len, same direction/width/meaning as aw_* counterparts, read side.
REQ-022 SHALL have port r_valid, output, 1, read beat valid.
REQ-023 SHALL have port r_ready, input, 1, read beat accepted.
REQ-024 SHALL have port r_data, output, DATA_W, read beat.
REQ-025 SHALL have port r_resp, output, 2, 00 OKAY / 10 SLVERR.
REQ-026 SHALL have port r_last, output, 1, high on beat ar_len+1.
REQ-027 SHALL have port r_id, output, ID_W, echo of ar_id.

Function
REQ-030 SHALL run one FSM: IDLE, WR_DATA, WR_RESP, RD_DATA; one transaction at a time.
REQ-031 IDLE: AW and AR both valid -> grant opposite of last grant (round-robin, write first after reset); single valid -> grant it; aw_ready/ar_ready high only in the granted cycle.
REQ-032 AW handshake -> WR_DATA next cycle; latch id, len, word index = addr[log2(DATA_W/8) +: log2(MEM_DEPTH)]; low address bits ignored, full-width INCR bursts only.
REQ-033 WR_DATA: w_ready=1; each handshake writes bytes with w_strb set, index+1; after beat len+1 -> WR_RESP.
REQ-034 w_last asserted on any beat other than len+1, or absent on it, SHALL make b_resp=SLVERR; burst length still governed by aw_len.
REQ-035 WR_RESP: b_valid=1 held until b_ready, then IDLE; write data visible to a read granted the next cycle.
REQ-036 RD_DATA: r_valid rises the cycle after AR handshake; r_data/r_resp/r_id/r_last held stable while r_valid&&!r_ready; each handshake presents the next beat the following cycle (one beat/cycle sustained); after handshake of beat len+1 -> IDLE.
REQ-037 Index arithmetic SHALL be log2(MEM_DEPTH) bits, wrapping modulo MEM_DEPTH; aw_len/ar_len=255 (256 beats) supported.

Reset
REQ-040 Reset SHALL force IDLE, all ready/valid outputs 0, b_resp/r_resp 00, r_last 0, arbiter to write-first; memory contents not reset; a burst in progress is abandoned with no B/R issued.

Configuration
REQ-050 AXI_MEM_SLAVE_ADDR_CHECK_EN defined: any beat whose unwrapped address >= MEM_DEPTH*DATA_W/8 returns SLVERR, writes dropped, read data 0; undefined: addresses wrap per REQ-037, always OKAY except REQ-034.

Structure
REQ-060 FSM state enum and RESP_OKAY=2'b00/RESP_SLVERR=2'b10 SHALL live in shared package axi_pkg.
REQ-061 Storage SHALL be sub-module axi_mem_array (byte-enable write port, read port).

Verification
REQ-070 AW addr 0x100 len 3 + 4 beats strb 0xFF, then AR addr 0x100 len 3 -> B OKAY id echoed; R returns 4 beats, r_last on beat 4 only.
REQ-071 Write strb 0x0F data 0xAAAAAAAA_BBBBBBBB over 0x11111111_22222222 -> readback 0x11111111_BBBBBBBB.
REQ-072 AW and AR valid same cycle, twice -> write granted first, then read; next tie -> write again.
REQ-073 r_ready toggled 1/0 every cycle on len 7 read -> 8 beats, no duplicates/drops, data stable when stalled.
REQ-074 w_last on beat 2 of len 3 -> 4 beats accepted, b_resp=10; reset asserted mid read burst -> r_valid 0 next cycle, IDLE.
REQ-075 With AXI_MEM_SLAVE_ADDR_CHECK_EN, MEM_DEPTH 4096, read at byte 0x8000 -> r_resp=10, r_data=0; without, returns word 0.
